// File: rtl/circle_point_gen_if.sv
// CORDIC request/response pair and point output stream for circle_point_gen.
// The generator is the master; the CORDIC unit and plot stage sit on the slave side.
interface circle_point_gen_if #(
   parameter int COORD_W = 10
);
   logic                      cordic_start;
   logic [15:0]               cordic_angle;
   logic signed [15:0]        cordic_sine;
   logic signed [15:0]        cordic_cosine;
   logic                      cordic_done;
   logic [COORD_W-1:0]        point_x;
   logic [COORD_W-1:0]        point_y;
   logic                      point_valid;
   logic                      point_ready;

   modport master (
      output cordic_start, cordic_angle, point_x, point_y, point_valid,
      input  cordic_sine, cordic_cosine, cordic_done, point_ready
   );

   modport slave (
      input  cordic_start, cordic_angle, point_x, point_y, point_valid,
      output cordic_sine, cordic_cosine, cordic_done, point_ready
   );
endinterface

// File: rtl/circle_point_gen.sv
// Angle sweep sequencer around a CORDIC sin/cos unit: one request per step,
// result scaled by radius, offset by centre, clamped and streamed out as points.
module circle_point_gen #(
   parameter int COORD_W  = 10,
   parameter int RADIUS_W = 8,
   parameter int TIMEOUT  = 63
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 go,
   input  logic [8:0]           angle_start,
   input  logic [7:0]           angle_step,
   input  logic [9:0]           num_points,
   input  logic [RADIUS_W-1:0]  radius,
   input  logic [COORD_W-1:0]   center_x,
   input  logic [COORD_W-1:0]   center_y,
   output logic                 busy,
   output logic                 sweep_done,
   output logic                 cordic_timeout,
   circle_point_gen_if.master   bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_SKIP  = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_SCALE = 3'd4;
   localparam logic [2:0] S_EMIT  = 3'd5;

   localparam int PW = 16 + RADIUS_W + 1;
   localparam int SW = COORD_W + 2;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic signed [SW-1:0] COORD_MAX = SW'((1 << COORD_W) - 1);
   localparam logic [TW-1:0]        WAIT_LAST = TW'(TIMEOUT - 1);

   logic [2:0]                state;
   logic                      armed;
   logic [8:0]                angle_q;
   logic [7:0]                step_q;
   logic [9:0]                remain_q;
   logic [TW-1:0]             wait_cnt;
   logic [RADIUS_W-1:0]       radius_q;
   logic [COORD_W-1:0]        cx_q;
   logic [COORD_W-1:0]        cy_q;
   logic signed [15:0]        sin_p0;
   logic signed [15:0]        cos_p0;
   logic signed [PW-1:0]      prod_x_p0;
   logic signed [PW-1:0]      prod_y_p0;
   logic signed [SW-1:0]      tx_p0;
   logic signed [SW-1:0]      ty_p0;
   logic signed [SW-1:0]      sum_x_p0;
   logic signed [SW-1:0]      sum_y_p0;
   logic [9:0]                angle_sum;
   logic [8:0]                angle_next;

   function automatic logic [COORD_W-1:0] clamp_coord(input logic signed [SW-1:0] v);
      if (v < 0)
         return '0;
      else if (v > COORD_MAX)
         return '1;
      else
         return v[COORD_W-1:0];
   endfunction

   assign bus.cordic_angle = {7'd0, angle_q};

   // Advance the angle and keep it inside 0..359
   always_comb begin
      angle_sum  = {1'b0, angle_q} + {2'b00, step_q};
      angle_next = angle_q;
      if (angle_sum >= 10'd360)
         angle_next = 9'(angle_sum - 10'd360);
      else
         angle_next = angle_sum[8:0];
   end

   // Stage p0 -> output: scale the registered sin/cos by radius, floor shift, offset
   always_comb begin
      prod_x_p0 = PW'(cos_p0) * PW'($signed({1'b0, radius_q}));
      prod_y_p0 = PW'(sin_p0) * PW'($signed({1'b0, radius_q}));
      tx_p0     = SW'(prod_x_p0 >>> 14);
      ty_p0     = SW'(prod_y_p0 >>> 14);
      sum_x_p0  = $signed({2'b00, cx_q}) + tx_p0;
      sum_y_p0  = $signed({2'b00, cy_q}) - ty_p0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= S_IDLE;
         armed            <= 1'b0;
         angle_q          <= '0;
         step_q           <= '0;
         remain_q         <= '0;
         wait_cnt         <= '0;
         busy             <= 1'b0;
         sweep_done       <= 1'b0;
         cordic_timeout   <= 1'b0;
         bus.cordic_start <= 1'b0;
         bus.point_x      <= '0;
         bus.point_y      <= '0;
         bus.point_valid  <= 1'b0;
      end else begin
         // armed blocks a go that lands on the first edge after reset release
         armed            <= 1'b1;
         sweep_done       <= 1'b0;
         bus.cordic_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (busy) begin
                  busy       <= 1'b0;
                  sweep_done <= 1'b1;
               end else if (go && armed) begin
                  angle_q        <= angle_start;
                  step_q         <= angle_step;
                  remain_q       <= num_points;
                  cordic_timeout <= 1'b0;
                  busy           <= 1'b1;
                  if (num_points != 10'd0) begin
                     state            <= S_ISSUE;
                     bus.cordic_start <= 1'b1;
                  end
               end
            end
            S_ISSUE: state <= S_SKIP;
            S_SKIP: begin
               wait_cnt <= '0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.cordic_done) begin
                  state <= S_SCALE;
               end else if (wait_cnt == WAIT_LAST) begin
                  cordic_timeout <= 1'b1;
                  sweep_done     <= 1'b1;
                  busy           <= 1'b0;
                  state          <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_SCALE: begin
               bus.point_x     <= clamp_coord(sum_x_p0);
               bus.point_y     <= clamp_coord(sum_y_p0);
               bus.point_valid <= 1'b1;
               state           <= S_EMIT;
            end
            S_EMIT: begin
               if (bus.point_ready) begin
                  bus.point_valid <= 1'b0;
                  remain_q        <= remain_q - 10'd1;
                  angle_q         <= angle_next;
                  if (remain_q == 10'd1) begin
                     sweep_done <= 1'b1;
                     busy       <= 1'b0;
                     state      <= S_IDLE;
                  end else begin
                     bus.cordic_start <= 1'b1;
                     state            <= S_ISSUE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Datapath captures carry no reset; they are only consumed after being loaded
   always_ff @(posedge clk) begin
      if (state == S_IDLE && !busy && go) begin
         radius_q <= radius;
         cx_q     <= center_x;
         cy_q     <= center_y;
      end
      if (state == S_WAIT && bus.cordic_done) begin
         sin_p0 <= bus.cordic_sine;
         cos_p0 <= bus.cordic_cosine;
      end
   end

endmodule

// File: tb/tb_circle_point_gen.sv
// Bench for circle_point_gen: behavioural 33-cycle CORDIC, vector table of sweeps,
// scoreboard of expected angles and points, plus hold/timeout/reset sequences.
module tb_circle_point_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        go;
   logic [8:0]  angle_start;
   logic [7:0]  angle_step;
   logic [9:0]  num_points;
   logic [7:0]  radius;
   logic [9:0]  center_x;
   logic [9:0]  center_y;
   logic        busy;
   logic        sweep_done;
   logic        cordic_timeout;

   circle_point_gen_if #(.COORD_W(10)) bus();

   circle_point_gen #(.COORD_W(10), .RADIUS_W(8), .TIMEOUT(63)) dut (
      .clk            (clk),
      .reset          (reset),
      .go             (go),
      .angle_start    (angle_start),
      .angle_step     (angle_step),
      .num_points     (num_points),
      .radius         (radius),
      .center_x       (center_x),
      .center_y       (center_y),
      .busy           (busy),
      .sweep_done     (sweep_done),
      .cordic_timeout (cordic_timeout),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_starts = 0;
   int n_done = 0;
   int last_start_cyc = 0;
   int exp_ang[$];
   int exp_x[$];
   int exp_y[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural CORDIC: exact Q2.14 at multiples of 90 degrees, result after 33 cycles
   logic               model_en;
   logic               model_clr;
   logic signed [15:0] cos180;
   int                 mcnt;
   logic [15:0]        m_angle;

   always @(posedge clk) begin
      if (model_clr) begin
         bus.cordic_done   <= 1'b0;
         bus.cordic_sine   <= '0;
         bus.cordic_cosine <= '0;
         mcnt              <= 0;
      end else if (bus.cordic_start) begin
         bus.cordic_done <= 1'b0;
         mcnt            <= 33;
         m_angle         <= bus.cordic_angle;
      end else if (mcnt > 0) begin
         mcnt <= mcnt - 1;
         if (mcnt == 1 && model_en) begin
            bus.cordic_done <= 1'b1;
            case (m_angle)
               16'd0:   begin bus.cordic_sine <= 16'sd0;      bus.cordic_cosine <= 16'sd16384;  end
               16'd90:  begin bus.cordic_sine <= 16'sd16384;  bus.cordic_cosine <= 16'sd0;      end
               16'd180: begin bus.cordic_sine <= 16'sd0;      bus.cordic_cosine <= cos180;      end
               16'd270: begin bus.cordic_sine <= -16'sd16384; bus.cordic_cosine <= 16'sd0;      end
               default: begin bus.cordic_sine <= 16'sd0;      bus.cordic_cosine <= 16'sd16384;  end
            endcase
         end
      end
   end

   // Scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.cordic_start) begin
            n_starts++;
            last_start_cyc = cyc;
            if (exp_ang.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_start: angle %0d, none expected", bus.cordic_angle);
            end else
               check("cordic_angle", int'(bus.cordic_angle), exp_ang.pop_front());
         end
         if (bus.point_valid && bus.point_ready) begin
            if (exp_x.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_point: (%0d,%0d), none expected", bus.point_x, bus.point_y);
            end else begin
               check("point_x", int'(bus.point_x), exp_x.pop_front());
               check("point_y", int'(bus.point_y), exp_y.pop_front());
            end
         end
         if (sweep_done) n_done++;
      end
   end

   typedef struct packed {
      logic [8:0]       ang;
      logic [7:0]       step;
      logic [9:0]       npts;
      logic [7:0]       rad;
      logic [9:0]       cx;
      logic [9:0]       cy;
      logic [15:0]      c180;
      logic [3:0][8:0]  ea;
      logic [3:0][9:0]  ex;
      logic [3:0][9:0]  ey;
   } vec_t;

   localparam int NV = 6;
   vec_t vt[NV];

   task automatic set_vec(input int i, input int ang, input int step, input int n,
                          input int rad, input int cx, input int cy, input int c180);
      vt[i].ang = 9'(ang); vt[i].step = 8'(step); vt[i].npts = 10'(n);
      vt[i].rad = 8'(rad); vt[i].cx = 10'(cx); vt[i].cy = 10'(cy); vt[i].c180 = 16'(c180);
   endtask

   task automatic set_pt(input int i, input int k, input int a, input int x, input int y);
      vt[i].ea[k] = 9'(a); vt[i].ex[k] = 10'(x); vt[i].ey[k] = 10'(y);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_sweep(input int ang, input int step, input int n,
                              input int rad, input int cx, input int cy);
      tick();
      angle_start = 9'(ang); angle_step = 8'(step); num_points = 10'(n);
      radius = 8'(rad); center_x = 10'(cx); center_y = 10'(cy);
      go = 1'b1;
      tick();
      go = 1'b0;
   endtask

   task automatic wait_done(input int limit, input string tag);
      int k = 0;
      while (!sweep_done && k < limit) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (!sweep_done) begin
         n_bad++;
         $display("FAIL %s_done: sweep_done not seen within %0d cycles, expected pulse", tag, limit);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},        int'(busy), 0);
      check({tag, "_sweep_done"},  int'(sweep_done), 0);
      check({tag, "_timeout"},     int'(cordic_timeout), 0);
      check({tag, "_start"},       int'(bus.cordic_start), 0);
      check({tag, "_angle"},       int'(bus.cordic_angle), 0);
      check({tag, "_valid"},       int'(bus.point_valid), 0);
      check({tag, "_x"},           int'(bus.point_x), 0);
      check({tag, "_y"},           int'(bus.point_y), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int viol;
      int k;
      reset = 1'b1; go = 1'b0; angle_start = '0; angle_step = '0; num_points = '0;
      radius = '0; center_x = '0; center_y = '0;
      bus.point_ready = 1'b1;
      model_en = 1'b1; model_clr = 1'b1; cos180 = -16'sd16384;

      set_vec(0,   0, 90, 4, 100, 320, 240, -16384);
      set_pt (0, 0,   0, 420, 240); set_pt(0, 1,  90, 320, 140);
      set_pt (0, 2, 180, 220, 240); set_pt(0, 3, 270, 320, 340);
      set_vec(1, 350, 20, 2,  10, 100, 100, -16384);
      set_pt (1, 0, 350, 110, 100); set_pt(1, 1,  10, 110, 100);
      set_vec(2, 180,  1, 1, 200,  10,  10, 'hC006);
      set_pt (2, 0, 180,   0,  10);
      set_vec(3,   0,  5, 1, 255, 1000,  5, -16384);
      set_pt (3, 0,   0, 1023,  5);
      set_vec(4,  90,  5, 1, 100,   5,   5, -16384);
      set_pt (4, 0,  90,   5,   0);
      set_vec(5, 270,  5, 1,  50, 500, 1000, -16384);
      set_pt (5, 0, 270, 500, 1023);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      model_clr = 1'b0;
      tick();
      reset = 1'b0;
      tick(); tick();

      // Table-driven sweeps
      for (int i = 0; i < NV; i++) begin
         cos180 = signed'(vt[i].c180);
         for (int p = 0; p < int'(vt[i].npts); p++) begin
            exp_ang.push_back(int'(vt[i].ea[p]));
            exp_x.push_back(int'(vt[i].ex[p]));
            exp_y.push_back(int'(vt[i].ey[p]));
         end
         base = n_starts;
         start_sweep(vt[i].ang, vt[i].step, vt[i].npts, vt[i].rad, vt[i].cx, vt[i].cy);
         wait_done(1000, $sformatf("vec%0d", i));
         @(negedge clk);
         check($sformatf("vec%0d_starts", i), n_starts - base, int'(vt[i].npts));
         check($sformatf("vec%0d_busy", i), int'(busy), 0);
         check($sformatf("vec%0d_left", i), exp_x.size() + exp_ang.size(), 0);
      end
      cos180 = -16'sd16384;

      // Back-pressure: first point held 20 cycles, go during busy ignored
      exp_ang.push_back(0);  exp_x.push_back(420); exp_y.push_back(240);
      exp_ang.push_back(90); exp_x.push_back(320); exp_y.push_back(140);
      bus.point_ready = 1'b0;
      base = n_starts;
      start_sweep(0, 90, 2, 100, 320, 240);
      k = 0;
      while (!bus.point_valid && k < 200) begin @(negedge clk); k++; end
      check("hold_first_valid", int'(bus.point_valid), 1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 3) begin angle_start = 9'd45; num_points = 10'd0; go = 1'b1; end
         if (i == 4) go = 1'b0;
         check("hold_valid", int'(bus.point_valid), 1);
         check("hold_x", int'(bus.point_x), 420);
         check("hold_y", int'(bus.point_y), 240);
         check("hold_starts", n_starts - base, 1);
      end
      bus.point_ready = 1'b1;
      wait_done(1000, "hold");
      @(negedge clk);
      check("hold_total_starts", n_starts - base, 2);

      // CORDIC never answers: abort after 63 WAIT cycles
      model_en = 1'b0;
      exp_ang.push_back(0);
      start_sweep(0, 90, 1, 100, 320, 240);
      wait_done(300, "timeout");
      check("timeout_latency", cyc - last_start_cyc, 65);
      check("timeout_flag", int'(cordic_timeout), 1);
      check("timeout_busy", int'(busy), 0);
      model_en = 1'b1;
      exp_ang.push_back(0); exp_x.push_back(420); exp_y.push_back(240);
      start_sweep(0, 90, 1, 100, 320, 240);
      @(negedge clk);
      check("timeout_cleared", int'(cordic_timeout), 0);
      wait_done(1000, "after_timeout");

      // Reset during WAIT: outputs clear at once, late done yields nothing
      exp_ang.push_back(0);
      start_sweep(0, 90, 1, 100, 320, 240);
      repeat (12) @(negedge clk);
      #2 reset = 1'b1;
      #1 check_all_zero("async");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      viol = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.point_valid || busy) viol++;
      end
      check("late_done_ignored", viol, 0);

      // go coinciding with reset release is ignored
      base = n_starts;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; angle_start = '0; num_points = 10'd1; go = 1'b1;
      tick();
      go = 1'b0;
      viol = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (busy) viol++;
      end
      check("go_at_release_busy", viol, 0);
      check("go_at_release_starts", n_starts - base, 0);

      // Zero-length sweep: one sweep_done pulse, no CORDIC request
      base = n_starts;
      k = n_done;
      start_sweep(0, 90, 0, 100, 320, 240);
      repeat (6) @(negedge clk);
      check("zero_done_pulses", n_done - k, 1);
      check("zero_starts", n_starts - base, 0);
      check("zero_busy", int'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
